// File: rtl/nrzi_eop_encoder.sv
// USB full-speed NRZI line encoder with EOP (SE0 then J) generation, one bit per clock.
// Optional per-packet bit counter enabled by defining NRZI_BIT_COUNT_EN.
module nrzi_eop_encoder #(
  parameter int EOP_SE0_CYCLES = 2,
  parameter int IDLE_J_CYCLES  = 1
`ifdef NRZI_BIT_COUNT_EN
  , parameter int CNT_W        = 16
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             dp,
  output logic             dm,
  output logic             busy,
  output logic             eop_done,
  output logic             overrun
`ifdef NRZI_BIT_COUNT_EN
  , output logic [CNT_W-1:0] bit_count
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, SE0, EOPJ} state_t;

  localparam logic [2:0] SE0_LOAD = 3'(EOP_SE0_CYCLES - 1);
  localparam logic [2:0] J_LOAD   = 3'(IDLE_J_CYCLES - 1);
  localparam logic       J_LAST   = (IDLE_J_CYCLES == 1);

  state_t     state;
  logic [2:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dp       <= 1'b1;
      dm       <= 1'b0;
      busy     <= 1'b0;
      eop_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      eop_done <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Every packet starts from J: a 0 toggles to K, a 1 holds J.
            dp    <= in_bit;
            dm    <= ~in_bit;
            busy  <= 1'b1;
            state <= SEND;
          end else begin
            dp <= 1'b1;
            dm <= 1'b0;
          end
        end
        SEND: begin
          if (in_valid) begin
            dp <= in_bit ? dp : ~dp;
            dm <= in_bit ? dm : ~dm;
          end else begin
            dp    <= 1'b0;
            dm    <= 1'b0;
            cnt   <= SE0_LOAD;
            state <= SE0;
          end
        end
        SE0: begin
          overrun <= in_valid;
          if (cnt == '0) begin
            dp       <= 1'b1;
            dm       <= 1'b0;
            cnt      <= J_LOAD;
            eop_done <= J_LAST;
            state    <= EOPJ;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EOPJ: begin
          overrun <= in_valid;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt      <= cnt - 1'b1;
            eop_done <= (cnt == 3'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NRZI_BIT_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_count <= '0;
    end else if (state == IDLE && in_valid) begin
      bit_count <= CNT_W'(1);
    end else if (state == SEND && in_valid && bit_count != '1) begin
      bit_count <= bit_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nrzi_eop_encoder.sv
// Scoreboard bench for nrzi_eop_encoder: directed vectors push expected line state,
// a monitor pops and compares one entry per clock.
module tb_nrzi_eop_encoder;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic dp, dm, busy, eop_done, overrun;
`ifdef NRZI_BIT_COUNT_EN
  logic [15:0] bit_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [4:0] vec;
    int         bc;
  } exp_t;

  exp_t q[$];
  int   step_id = 0;

  nrzi_eop_encoder #(.EOP_SE0_CYCLES(2), .IDLE_J_CYCLES(1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .dp       (dp),
    .dm       (dm),
    .busy     (busy),
    .eop_done (eop_done),
    .overrun  (overrun)
`ifdef NRZI_BIT_COUNT_EN
    , .bit_count(bit_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int id, input logic [4:0] a, input logic [4:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s #%0d {dp,dm,busy,eop_done,overrun} act=%b exp=%b", nm, id, a, e);
    end
    checks++;
    if (a[4] === 1'b1 && a[3] === 1'b1) begin
      errors++;
      $display("FAIL %s_se1 #%0d dp=%b dm=%b exp not both 1", nm, id, a[4], a[3]);
    end
  endtask

  task automatic chk_bc(input string nm, input int id, input int e);
`ifdef NRZI_BIT_COUNT_EN
    checks++;
    if (int'(bit_count) != e) begin
      errors++;
      $display("FAIL %s_bit_count #%0d act=%0d exp=%0d", nm, id, bit_count, e);
    end
`endif
  endtask

  // Drive one input cycle and record the outputs expected after the edge that samples it.
  task automatic step(input logic v, input logic b, input logic edp, input logic edm,
                      input logic ebusy, input logic eeop, input logic eovr, input int ebc);
    exp_t e;
    @(negedge clock);
    in_valid = v;
    in_bit   = b;
    step_id++;
    e.id  = step_id;
    e.vec = {edp, edm, ebusy, eeop, eovr};
    e.bc  = ebc;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("line", e.id, {dp, dm, busy, eop_done, overrun}, e.vec);
        chk_bc("line", e.id, e.bc);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  logic [7:0] sync_bits;
  logic [7:0] sync_dp;

  initial begin
    // Reset asserted mid-clock takes effect without an edge.
    #2 reset_n = 1'b0;
    #1 chk("reset_async", 0, {dp, dm, busy, eop_done, overrun}, 5'b10000);
    chk_bc("reset_async", 0, 0);
    repeat (2) @(posedge clock);
    #1 chk("reset_hold", 0, {dp, dm, busy, eop_done, overrun}, 5'b10000);
    @(negedge clock);
    reset_n = 1'b1;

    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // SYNC pattern.
    sync_bits = 8'b1000_0000;
    sync_dp   = 8'b0010_1010;
    for (int unsigned i = 0; i < 8; i++) begin
      step(1, sync_bits[i], sync_dp[i], ~sync_dp[i], 1, 0, 0, int'(i) + 1);
    end

    // EOP: two SE0 cycles, one J with eop_done, then idle.
    step(0, 0, 0, 0, 1, 0, 0, 8);
    step(0, 0, 0, 0, 1, 0, 0, 8);
    step(0, 0, 1, 0, 1, 1, 0, 8);
    step(0, 0, 1, 0, 0, 0, 0, 8);

    // Packet starting with a 1 (holds J), then overrun during the first SE0 cycle.
    step(1, 1, 1, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 0, 0, 2);
    step(0, 0, 0, 0, 1, 0, 0, 2);
    step(1, 0, 0, 0, 1, 0, 1, 2);
    step(0, 0, 1, 0, 1, 1, 0, 2);
    step(0, 0, 1, 0, 0, 0, 0, 2);

    // Back-to-back packet in the idle cycle right after eop_done, then reset after 5 bits.
    step(1, 0, 0, 1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 1, 0, 0, 2);
    step(1, 0, 1, 0, 1, 0, 0, 3);
    step(1, 0, 0, 1, 1, 0, 0, 4);
    step(1, 1, 0, 1, 1, 0, 0, 5);
    @(posedge clock);
    #3;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1 chk("reset_midpkt", 0, {dp, dm, busy, eop_done, overrun}, 5'b10000);
    chk_bc("reset_midpkt", 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // No EOP after reset; next packet encodes from J.
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d pending exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
